rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with grant lock and hold timeout.
- Shares one downstream resource, such as a shared bus or register-file port, between four clients.
- Issues a one-hot grant plus a 2-bit encoded grant index for muxing and tagging.
- Rotating priority guarantees no starvation; the hold timeout prevents one client monopolising the resource.

Parameters:
- HOLD_W, 8, width of the hold counter.
- MAX_HOLD, 16, maximum cycles one grant may be held; 0 disables the timeout; must be < 2^HOLD_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- arb_req  input  4  request lines; bit i = client i; level-sensitive.
- arb_gnt  output  4  one-hot grant, registered; all-zero when no grant.
- arb_gnt_idx  output  2  encoded index of the granted client; holds its last value when arb_gnt_valid=0.
- arb_gnt_valid  output  1  high while any grant is active (equals |arb_gnt).
- arb_timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the timeout.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-grant):
  - arb_gnt=4'b0000, arb_gnt_idx=2'd0, arb_gnt_valid=0, arb_timeout=0.
  - Internal: state=IDLE, priority pointer ptr=2'd0, hold_cnt=0.
- All outputs are registered; no combinational path from arb_req to any output.
- State machine, two states:
  - IDLE: if arb_req==0, stay in IDLE.
  - IDLE: otherwise select the first set bit scanning circularly ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge, assert arb_gnt[sel]=1, arb_gnt_idx=sel, arb_gnt_valid=1, hold_cnt=0, and go to GRANT.
  - Latency is one cycle from request seen in IDLE to grant visible.
  - GRANT: grant outputs are held stable; hold_cnt increments by 1 each cycle, saturating at 2^HOLD_W-1.
  - GRANT, normal release: arb_req[arb_gnt_idx]==0 sampled at an edge.
  - GRANT, timeout release: MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 while the request is still high.
  - On either release, at that edge: arb_gnt=0, arb_gnt_valid=0, ptr=arb_gnt_idx+1 (mod 4, wraps 3->0), state=IDLE.
- Arbitration bubble:
  - Every release is followed by exactly one cycle with arb_gnt=0.
  - Re-arbitration happens in that IDLE cycle.
  - Minimum grant-to-grant spacing is therefore one empty cycle.
- Timeout:
  - Grant duration with the request held high is exactly MAX_HOLD cycles.
  - arb_timeout=1 in the first cycle after a timeout release, 0 otherwise.
  - If the request drops on the same edge the timeout would fire, treat it as a normal release with no arb_timeout pulse.
- Fairness:
  - After any release the released client has lowest priority.
  - A sole requester is re-granted after the one-cycle bubble, including after a timeout.
- Changes to non-granted arb_req bits during GRANT are ignored until the next IDLE.
- ptr is updated only on release.
- MAX_HOLD=1: every grant lasts one cycle, then a bubble follows; arb_timeout pulses each time the request stays high.
- Invariants:
  - arb_gnt always has at most one bit set.
  - arb_gnt_valid==|arb_gnt.
  - When valid, arb_gnt[arb_gnt_idx]==1.

Test Plan:
1. Reset, then arb_req=4'b0100 held -> after 1 cycle arb_gnt=4'b0100, arb_gnt_idx=2, arb_gnt_valid=1; drop req -> next cycle arb_gnt=0, ptr=3.
2. From reset (ptr=0), arb_req=4'b1111 held, each client drops its req one cycle after being granted -> grant order idx 0,1,2,3,0 with one zero-grant cycle between grants.
3. MAX_HOLD=16, arb_req=4'b0010 held continuously -> arb_gnt=4'b0010 for exactly 16 cycles, then arb_gnt=0 with arb_timeout=1 for 1 cycle, then re-grant to idx 1.
4. MAX_HOLD=16, client 0 granted and held, client 2 requesting -> after 16 cycles timeout, bubble, grant to idx 2; client 0 re-granted only after client 2 releases.
5. Request drop coincident with hold_cnt==MAX_HOLD-1 -> release, arb_timeout stays 0.
6. Assert reset mid-GRANT with arb_gnt=4'b1000 -> all outputs 0 immediately without a clock edge; after deassert with arb_req=4'b1001 -> grant idx 0 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between four clients and the round-robin arbiter.
interface rr_arbiter4_if;
  logic [3:0] arb_req;
  logic [3:0] arb_gnt;
  logic [1:0] arb_gnt_idx;
  logic       arb_gnt_valid;
  logic       arb_timeout;
  modport master (output arb_req, input arb_gnt, arb_gnt_idx, arb_gnt_valid, arb_timeout);
  modport slave  (input arb_req, output arb_gnt, arb_gnt_idx, arb_gnt_valid, arb_timeout);
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-client round-robin arbiter with registered one-hot grant and hold timeout.
module rr_arbiter4 #(
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         reset,
  rr_arbiter4_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            r_state, w_state_n;
  logic [3:0]        r_gnt, w_gnt_n, w_rot;
  logic [1:0]        r_idx, w_idx_n, r_ptr, w_ptr_n, w_off, w_sel;
  logic [HOLD_W-1:0] r_hold, w_hold_n;
  logic              r_to, w_to_n, w_drop, w_expire;
  // Rotate requests so bit 0 is the highest-priority client, then pick the first set bit.
  assign w_rot    = 4'({bus.arb_req, bus.arb_req} >> r_ptr);
  assign w_off    = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign w_sel    = r_ptr + w_off;
  assign w_drop   = !bus.arb_req[r_idx];
  // A request dropping on the expiry edge counts as a normal release.
  assign w_expire = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD - 1)) && !w_drop;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_idx   <= w_idx_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
      r_to    <= w_to_n;
    end
  end
  always_comb
    w_state_n = (r_state == IDLE) ? ((|bus.arb_req) ? GRANT : IDLE)
                                  : ((w_drop || w_expire) ? IDLE : GRANT);
  always_comb begin
    w_gnt_n  = r_gnt;
    w_idx_n  = r_idx;
    w_ptr_n  = r_ptr;
    w_to_n   = 1'b0;
    w_hold_n = (&r_hold) ? r_hold : r_hold + HOLD_W'(1);
    if (r_state == IDLE) begin
      w_hold_n = '0;
      if (|bus.arb_req) begin
        w_gnt_n = 4'b0001 << w_sel;
        w_idx_n = w_sel;
      end
    end else if (w_drop || w_expire) begin
      w_gnt_n = '0;
      w_ptr_n = r_idx + 2'd1;
      w_to_n  = w_expire;
    end
  end
  assign bus.arb_gnt       = r_gnt;
  assign bus.arb_gnt_idx   = r_idx;
  assign bus.arb_gnt_valid = |r_gnt;
  assign bus.arb_timeout   = r_to;
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: random and directed stimulus against a client-level round-robin model.
module tb_rr_arbiter4;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  rr_arbiter4_if bus ();
  rr_arbiter4 #(.HOLD_W(8), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_err = 0;
  int owner = -1;
  int held = 0;
  int last = 3;
  int m_idx = 0;
  bit m_to = 1'b0;
  logic [3:0] r;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    owner = -1; held = 0; last = 3; m_idx = 0; m_to = 1'b0;
  endtask
  // Owner-based model: who holds the resource, for how many cycles, who was served last.
  task automatic model_step(input logic [3:0] q);
    m_to = 1'b0;
    if (owner < 0) begin
      if (q != 0) begin
        for (int k = 1; k <= 4; k++)
          if (owner < 0 && q[(last + k) % 4]) owner = (last + k) % 4;
        m_idx = owner;
        held = 1;
      end
    end else if (!q[owner]) begin
      last = owner; owner = -1;
    end else if (MAX_HOLD != 0 && held == MAX_HOLD) begin
      last = owner; owner = -1; m_to = 1'b1;
    end else held++;
  endtask
  task automatic compare();
    chk("gnt", 32'(bus.arb_gnt), owner < 0 ? 32'd0 : 32'd1 << owner);
    chk("idx", 32'(bus.arb_gnt_idx), 32'(m_idx));
    chk("valid", 32'(bus.arb_gnt_valid), owner >= 0 ? 32'd1 : 32'd0);
    chk("timeout", 32'(bus.arb_timeout), 32'(m_to));
  endtask
  task automatic cycle(input logic [3:0] q);
    bus.arb_req = q;
    @(posedge clk);
    model_step(q);
    #1 compare();
  endtask
  initial begin
    bus.arb_req = 4'b0000;
    #12 compare();
    reset = 1'b0;
    repeat (2) cycle(4'b0100);
    repeat (2) cycle(4'b0000);
    r = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      cycle(r);
      r = (owner >= 0) ? (4'b1111 & ~(4'b0001 << owner)) : 4'b1111;
    end
    repeat (2) cycle(4'b0000);
    repeat (40) cycle(4'b0010);
    repeat (2) cycle(4'b0000);
    cycle(4'b0001);
    repeat (40) cycle(4'b0101);
    repeat (25) cycle(4'b0001);
    repeat (2) cycle(4'b0000);
    for (int i = 0; i < 40 && !(owner == 0 && held == MAX_HOLD); i++) cycle(4'b0001);
    chk("pre_drop_held", 32'(held), 32'(MAX_HOLD));
    cycle(4'b0000);
    chk("coincident_drop_no_timeout", 32'(bus.arb_timeout), 32'd0);
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      cycle(r);
    end
    for (int i = 0; i < 300; i++) cycle(4'($urandom));
    repeat (2) cycle(4'b0000);
    repeat (3) cycle(4'b1000);
    chk("pre_reset_gnt", 32'(bus.arb_gnt), 32'h8);
    #4 bus.arb_req = 4'b1001;
    reset = 1'b1;
    model_reset();
    #1 compare();
    #10 reset = 1'b0;
    repeat (3) cycle(4'b1001);
    chk("post_reset_idx", 32'(bus.arb_gnt_idx), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
